// File: rtl/log2_sched_pkg.sv
// Shared types and constants for the Log2 core scheduler.
package log2_sched_pkg;

    localparam int DATA_W = 8;
    localparam int INT_W  = 3;
    localparam int FRAC_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the watchdog counter; it must be able to hold TIMEOUT-1.
    function automatic int wd_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above pointer, wrapping.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] pointer,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    int j;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(pointer) + i) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                index    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/log2_scheduler.sv
// Shares one multi-cycle Log2 core among N_REQ requesters with round-robin
// arbitration, a core watchdog and owner-tagged responses.
module log2_scheduler #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    log_h,
    output logic [DATA_W-1:0]       log_in,
    input  logic                    log_flag,
    input  logic [DATA_W-1:0]       log_out
);
    import log2_sched_pkg::*;

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = wd_width(TIMEOUT);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic               log_h_q, log_h_d;
    logic [DATA_W-1:0]  log_in_q, log_in_d;
    logic               busy_q, busy_d;

    logic [N_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic [DATA_W-1:0]  win_data;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (req),
        .pointer (ptr_q),
        .grant   (arb_grant),
        .index   (arb_idx),
        .any     (arb_any)
    );

    // One-hot mux of the winner's operand slice.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) win_data = win_data | req_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        wd_d        = wd_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        log_h_d     = log_h_q;
        log_in_d    = log_in_q;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    log_in_d = win_data;
                    log_h_d  = 1'b1;
                    gnt_d    = arb_grant;
                    owner_d  = arb_idx;
                    ptr_d    = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    wd_d     = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // A flag arriving on the watchdog's last cycle still counts as success.
                if (log_flag) begin
                    rsp_data_d  = log_out;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = N_REQ'(1) << owner_q;
                    log_h_d     = 1'b0;
                    state_d     = DONE;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = N_REQ'(1) << owner_q;
                    log_h_d     = 1'b0;
                    state_d     = DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                log_h_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            wd_q        <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            log_h_q     <= 1'b0;
            log_in_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            wd_q        <= wd_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            log_h_q     <= log_h_d;
            log_in_q    <= log_in_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign log_h     = log_h_q;
    assign log_in    = log_in_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_log2_scheduler.sv
// Bench for log2_scheduler: behavioural Log2 core, job-level reference model,
// directed scenarios followed by a randomized regression.
module tb_log2_scheduler;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      gnt, rsp_valid;
    logic [DW-1:0]     rsp_data, log_in, log_out;
    logic              rsp_err, busy, log_h, log_flag;
    logic              core_flag;
    logic              stray = 1'b0;

    always #5 clk = ~clk;

    log2_scheduler #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .log_h     (log_h),
        .log_in    (log_in),
        .log_flag  (log_flag),
        .log_out   (log_out)
    );

    // floor(log2(x) * 32) in 3.5 fixed point, 0 for x == 0
    function automatic logic [7:0] golden(input logic [7:0] x);
        real r;
        int  v;
        if (x == 8'd0) return 8'd0;
        r = $ln(real'(x)) / $ln(2.0) * 32.0 + 1.0e-9;
        v = $rtoi(r);
        if (v > 255) v = 255;
        return 8'(v);
    endfunction

    // Behavioural Log2 core: raises flag core_lat cycles after h is seen high.
    int core_cnt;
    int core_lat = 2;
    bit core_en  = 1'b1;
    assign log_flag = core_flag | stray;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            core_cnt  <= 0;
            core_flag <= 1'b0;
            log_out   <= '0;
        end else begin
            core_flag <= 1'b0;
            if (log_h && !core_flag) begin
                if (core_en && core_cnt >= core_lat - 1) begin
                    core_flag <= 1'b1;
                    log_out   <= golden(log_in);
                    core_cnt  <= 0;
                end else begin
                    core_cnt <= core_cnt + 1;
                end
            end else begin
                core_cnt <= 0;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: one job at a time, one response cycle, then free again.
    bit         m_job, m_gap, m_err;
    int         m_owner, m_ptr, m_wait;
    logic [7:0] m_oper, m_data;
    int         gcount[N];
    int         nresp;

    task automatic model_reset();
        m_job = 0; m_gap = 0; m_err = 0; m_owner = 0; m_ptr = 0; m_wait = 0;
        m_oper = '0; m_data = '0;
    endtask

    task automatic tick();
        logic [N-1:0] e_gnt, e_rv;
        int w;
        e_gnt = '0;
        e_rv  = '0;
        w     = -1;
        if (!m_job && !m_gap) begin
            if (req != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                end
                e_gnt[w] = 1'b1;
                m_owner  = w;
                m_ptr    = (w + 1) % N;
                m_job    = 1;
                m_wait   = 0;
                m_oper   = req_data[w*DW +: DW];
            end
        end else if (m_job) begin
            if (log_flag) begin
                e_rv[m_owner] = 1'b1; m_data = log_out; m_err = 0; m_job = 0; m_gap = 1;
            end else if (m_wait == TO - 1) begin
                e_rv[m_owner] = 1'b1; m_data = '0; m_err = 1; m_job = 0; m_gap = 1;
            end else begin
                m_wait++;
            end
        end else begin
            m_gap = 0;
        end
        @(negedge clk);
        chk("gnt", gnt, e_gnt);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_err", rsp_err, m_err);
        chk("log_h", log_h, m_job);
        chk("busy", busy, m_job || m_gap);
        if (m_job) chk("log_in", log_in, m_oper);
        if (e_rv != '0 && !m_err) chk("golden", rsp_data, golden(m_oper));
        for (int i = 0; i < N; i++) if (gnt[i]) gcount[i]++;
        if (rsp_valid != '0) nresp++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_log_h", log_h, 0);
        chk("rst_log_in", log_in, 0);
        chk("rst_busy", busy, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_gnt(input int bound);
        bit seen;
        seen = 0;
        for (int c = 0; c < bound && !seen; c++) begin
            tick();
            if (gnt != '0) seen = 1;
        end
        chk("gnt_seen", seen, 1);
    endtask

    task automatic wait_rsp(input int bound);
        bit seen;
        seen = 0;
        for (int c = 0; c < bound && !seen; c++) begin
            tick();
            if (rsp_valid != '0) seen = 1;
        end
        chk("rsp_seen", seen, 1);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) tick();
    endtask

    task automatic run_single(input int r, input logic [7:0] x, input logic [7:0] expv);
        req_data[r*DW +: DW] = x;
        req[r] = 1'b1;
        tick();
        chk("gnt_latency", gnt, 1 << r);
        req[r] = 1'b0;
        wait_rsp(200);
        chk("single_data", rsp_data, expv);
        chk("single_owner", rsp_valid, 1 << r);
        chk("single_err", rsp_err, 0);
        idle(2);
    endtask

    logic [7:0] ops4[4] = '{8'd1, 8'd2, 8'd4, 8'd8};
    logic [7:0] exp4[4] = '{8'h00, 8'h20, 8'h40, 8'h60};
    logic [N-1:0] pend;
    int hcount, tot, gmin, gmax, cyc;

    initial begin
        model_reset();
        do_reset();
        idle(2);

        // Single requester through the directed operand list.
        run_single(0, 8'd8,   8'h60);
        run_single(0, 8'd2,   8'h20);
        run_single(0, 8'd3,   8'h32);
        run_single(0, 8'd255, 8'hFF);
        run_single(0, 8'd1,   8'h00);
        run_single(0, 8'd0,   8'h00);

        // All four requesters fresh from reset: strict rotation 0,1,2,3.
        do_reset();
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = ops4[i];
        req = 4'hF;
        for (int j = 0; j < N; j++) begin
            wait_gnt(20);
            chk("rot_gnt", gnt, 1 << j);
            if (j == N - 1) req = '0;
            wait_rsp(50);
            chk("rot_owner", rsp_valid, 1 << j);
            chk("rot_data", rsp_data, exp4[j]);
        end
        idle(2);

        // Pointer has wrapped to 0: requester 1 beats requester 3.
        req_data[1*DW +: DW] = 8'd16;
        req_data[3*DW +: DW] = 8'd32;
        req = 4'b1010;
        tick();
        chk("wrap_first", gnt, 4'b0010);
        req[1] = 1'b0;
        wait_rsp(50);
        wait_gnt(10);
        chk("wrap_second", gnt, 4'b1000);
        req[3] = 1'b0;
        wait_rsp(50);
        chk("wrap_data", rsp_data, 8'hA0);
        idle(2);

        // Stray core flag while idle is ignored.
        stray = 1'b1;
        tick();
        stray = 1'b0;
        idle(2);

        // Watchdog: core never answers.
        core_en = 1'b0;
        req_data[1*DW +: DW] = 8'd5;
        req[1] = 1'b1;
        tick();
        req[1] = 1'b0;
        hcount = (log_h === 1'b1) ? 1 : 0;
        for (int c = 0; c < 200 && rsp_valid == '0; c++) begin
            tick();
            if (log_h === 1'b1) hcount++;
        end
        chk("to_h_cycles", hcount, 64);
        chk("to_owner", rsp_valid, 4'b0010);
        chk("to_err", rsp_err, 1);
        chk("to_data", rsp_data, 0);
        core_en = 1'b1;
        idle(2);
        run_single(1, 8'd16, 8'h80);

        // Flag on the watchdog's last cycle wins; one cycle later it is a timeout.
        core_lat = 63;
        run_single(2, 8'd9, 8'h65);
        core_lat = 64;
        req_data[2*DW +: DW] = 8'd9;
        req[2] = 1'b1;
        tick();
        req[2] = 1'b0;
        wait_rsp(200);
        chk("late_flag_err", rsp_err, 1);
        idle(3);
        core_lat = 20;

        // Reset in the middle of a job.
        req_data[2*DW +: DW] = 8'd7;
        req[2] = 1'b1;
        tick();
        req[2] = 1'b0;
        idle(3);
        do_reset();
        idle(30);
        core_lat = 2;
        req_data[0*DW +: DW] = 8'd9;
        req_data[3*DW +: DW] = 8'd200;
        req = 4'b1001;
        tick();
        chk("post_rst_ptr", gnt, 4'b0001);
        req[0] = 1'b0;
        wait_rsp(50);
        wait_gnt(10);
        req[3] = 1'b0;
        wait_rsp(50);
        idle(2);
        run_single(2, 8'd7, 8'h59);

        // Random regression against the reference model.
        pend  = '0;
        nresp = 0;
        for (cyc = 0; cyc < 20000 && nresp < 216; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    req_data[i*DW +: DW] = 8'($urandom);
                end
            end
            req = pend;
            core_lat = $urandom_range(1, 6);
            tick();
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) begin
                    pend[i] = 1'($urandom_range(0, 1));
                    if (pend[i]) req_data[i*DW +: DW] = 8'($urandom);
                end
            end
        end
        chk("rand_jobs", nresp >= 216, 1);

        // Saturated load: all requesters always pending, grants must stay balanced.
        for (int i = 0; i < N; i++) gcount[i] = 0;
        req = 4'hF;
        tot = 0;
        for (cyc = 0; cyc < 3000 && tot < 40; cyc++) begin
            core_lat = $urandom_range(1, 6);
            tick();
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) begin
                    tot++;
                    req_data[i*DW +: DW] = 8'($urandom);
                end
            end
        end
        req = '0;
        gmin = gcount[0];
        gmax = gcount[0];
        for (int i = 1; i < N; i++) begin
            if (gcount[i] < gmin) gmin = gcount[i];
            if (gcount[i] > gmax) gmax = gcount[i];
        end
        chk("sat_jobs", tot, 40);
        chk("fair_skew", (gmax - gmin) <= 1, 1);
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
